pwm_peripheral: RTL and testbench
=================================

# pwm_peripheral

Consumer of the SPI-written control registers. Drives 16 output pins, each one of three ways: forced low, forced high, or a shared 8-bit-duty PWM waveform. The waveform runs on a prescaled free-running timebase. The duty value is shadowed at period boundaries, so a register write never produces a runt or glitched pulse. Outputs go straight to the chip's output pins (`uo_out`/`uio_out`).

## Interface
Parameters:
- `CLK_DIV`, default 13: clk cycles per PWM counter step. Period is 256*CLK_DIV cycles, about 3 kHz at a 10 MHz clk. Legal range is 1..4095.

Ports:
- `clk`  in  1  system clock; the single clock domain of the block.
- `rst`  in  1  reset, synchronous and active-high.
- `en_reg_out_7_0`  in  8  output enable, bits 7:0.
- `en_reg_out_15_8`  in  8  output enable, bits 15:8.
- `en_reg_pwm_7_0`  in  8  PWM mode select, bits 7:0.
- `en_reg_pwm_15_8`  in  8  PWM mode select, bits 15:8.
- `pwm_duty_cycle`  in  8  shared duty value; 0x00 is 0%, 0xFF is 100%.
- `out`  out  16  output pins; `out[i]` corresponds to enable bit i.

All register inputs come from clk-domain flops in the SPI block. No synchronisers are needed here.

## Operation
- **Prescaler `div_cnt`:** counts 0..CLK_DIV-1, then wraps. `tick` is asserted in the cycle where `div_cnt == CLK_DIV-1`. With CLK_DIV=1, `tick` is high every cycle.
- **Step counter `pwm_cnt` (8 bit):** increments on `tick` and wraps 0xFF to 0x00.
- **`period_end`:** `tick && pwm_cnt == 0xFF`.
- **Duty shadow `duty_q`:** loads `pwm_duty_cycle` on `period_end`; otherwise it holds its value.
- **PWM level `pwm_lvl`:**
  - 1 if `duty_q == 0xFF`.
  - Otherwise `pwm_cnt < duty_q`, an unsigned 8-bit compare.
  - `duty_q == 0x00` gives a constant 0.
- **Per-bit output, with en_out = {15_8, 7_0} and en_pwm likewise:**
  - `en_out[i] == 0` gives 0, regardless of `en_pwm[i]`.
  - `en_out[i] == 1` and `en_pwm[i] == 0` gives 1 (static high).
  - `en_out[i] == 1` and `en_pwm[i] == 1` gives `pwm_lvl`.
- **Update timing:**
  - `out` is registered.
  - Enable and mode changes take effect immediately and are not shadowed.
  - Only the duty value waits for the period boundary.
- **Reset values:** `div_cnt`, `pwm_cnt`, `duty_q` and `out` are all 0.
  - After reset, PWM-mode pins are low for the whole first period, because `duty_q` is 0.
- **Reset mid-period:** all state clears in the next cycle and the timebase restarts from 0. Any pending duty value is discarded and reloaded at the next `period_end`.
- **Duty write in the `period_end` cycle:** the value present on `pwm_duty_cycle` in that cycle is the one captured.

## Timing
- **Output latency:** `out` reflects an enable, mode or `pwm_lvl` change one clk after the inputs change.
- **Period:** exactly 256*CLK_DIV clk cycles, measured rising edge to rising edge.
- **High time per period:**
  - duty*CLK_DIV cycles for duty 0x00..0xFE.
  - The full period for 0xFF, with no low cycle.
- **Phase:** the rising edge of `out` (PWM mode) occurs one clk after `pwm_cnt` becomes 0x00.
- **Duty-change latency:** a new duty value takes effect at the first period start after the write. The worst case is one full period plus 1 clk.
- **Throughput:** no handshake. The block is always running and the inputs are level-sampled every cycle.

## Structure
- **Shared package `pwm_pkg`:**
  - `PWM_STEPS` = 256.
  - `DUTY_FULL` = 8'hFF.
  - Register address constants 7'h00..7'h04: EN_OUT_LO, EN_OUT_HI, EN_PWM_LO, EN_PWM_HI, DUTY.
  - The SPI register block and this block share these address constants.
- **Sub-module `pwm_timebase`:**
  - Contains the prescaler and step counter.
  - Parameter: `CLK_DIV`.
  - Outputs: `pwm_cnt[7:0]`, `tick`, `period_end`.
- **Top:** duty shadow, compare, output mux and output register.

## Test plan
All scenarios use CLK_DIV=2 (period 512 cycles) unless noted.
- **Reset:** en_out=0xFFFF, en_pwm=0x0000, duty=0x80, rst high for 3 cycles -> `out`=0x0000 through the cycle after rst falls, then 0xFFFF.
- **Static enables:** en_out=0x00F0, en_pwm=0x0000 -> `out`=0x00F0 one clk later. Then set en_pwm=0x00FF with duty_q=0 -> `out`=0x0000.
- **50% duty:** en_out=en_pwm=0xFFFF, duty=0x80 -> from the second period, every bit is high for 256 cycles and low for 256 cycles, with a 512-cycle period. Repeat with CLK_DIV=13 -> 1664 high / 3328 period.
- **Duty extremes:**
  - duty=0x00 -> constant 0 across 3 periods.
  - duty=0xFF -> constant 1 with no low cycle.
  - duty=0x01 -> exactly 2 high cycles per period.
- **Mid-period change:** duty_q=0x40; write 0xC0 when pwm_cnt=0x20 -> the current period keeps a 128-cycle high time; the next period has 384, with no extra edges.
- **Reset mid-period:** assert rst at pwm_cnt=0x90 with duty_q=0x80 -> `out`=0 next clk, counter restarts at 0, and the first period after reset is fully low.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared constants, types and helpers for the PWM output block and the SPI register block.
package pwm_pkg;

  localparam int unsigned PWM_STEPS  = 256;
  localparam int unsigned CNT_W      = 8;
  localparam int unsigned DUTY_W     = 8;
  localparam int unsigned DIV_W      = 12;
  localparam int unsigned NUM_PINS   = 16;
  localparam int unsigned REG_ADDR_W = 7;

  localparam logic [DUTY_W-1:0] DUTY_FULL = 8'hFF;
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(PWM_STEPS - 1);

  // Register map shared with the SPI register block
  localparam logic [REG_ADDR_W-1:0] EN_OUT_LO = 7'h00;
  localparam logic [REG_ADDR_W-1:0] EN_OUT_HI = 7'h01;
  localparam logic [REG_ADDR_W-1:0] EN_PWM_LO = 7'h02;
  localparam logic [REG_ADDR_W-1:0] EN_PWM_HI = 7'h03;
  localparam logic [REG_ADDR_W-1:0] DUTY      = 7'h04;

  // How a single pin is driven
  typedef enum logic [1:0] {
    PIN_OFF  = 2'd0,
    PIN_HIGH = 2'd1,
    PIN_PWM  = 2'd2
  } pin_mode_e;

  // Register-side configuration bundle as seen by the PWM block
  typedef struct packed {
    logic [NUM_PINS-1:0] en_out;
    logic [NUM_PINS-1:0] en_pwm;
    logic [DUTY_W-1:0]   duty;
  } pwm_cfg_t;

  // Output enable dominates; the PWM select only matters for enabled pins
  function automatic pin_mode_e pin_mode(input logic en_out, input logic en_pwm);
    pin_mode_e mode;
    mode = PIN_OFF;
    if (en_out) begin
      mode = en_pwm ? PIN_PWM : PIN_HIGH;
    end
    return mode;
  endfunction

  // Full-scale duty is forced high so 0xFF gives a waveform with no low cycle
  function automatic logic pwm_level(input logic [CNT_W-1:0] cnt, input logic [DUTY_W-1:0] duty);
    return (duty == DUTY_FULL) || (cnt < duty);
  endfunction

endpackage

// File: rtl/pwm_timebase.sv
// Free-running PWM timebase: clock prescaler followed by an 8-bit step counter.
module pwm_timebase
  import pwm_pkg::*;
#(
  parameter int unsigned CLK_DIV = 13
) (
  input  logic             clk,
  input  logic             rst,
  output logic [CNT_W-1:0] pwm_cnt,
  output logic             tick,
  output logic             period_end
);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt;

  // Prescaler counts 0..CLK_DIV-1 and wraps on tick
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  assign tick = (div_cnt == DIV_LAST);

  // Step counter advances once per tick and wraps naturally at 0xFF
  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_cnt <= '0;
    end else if (tick) begin
      pwm_cnt <= pwm_cnt + CNT_W'(1);
    end
  end

  assign period_end = tick && (pwm_cnt == CNT_LAST);

endmodule

// File: rtl/pwm_peripheral.sv
// 16-pin output block: each pin forced low, forced high, or driven by a shared shadowed-duty PWM.
module pwm_peripheral
  import pwm_pkg::*;
#(
  parameter int unsigned CLK_DIV = 13
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          en_reg_out_7_0,
  input  logic [7:0]          en_reg_out_15_8,
  input  logic [7:0]          en_reg_pwm_7_0,
  input  logic [7:0]          en_reg_pwm_15_8,
  input  logic [DUTY_W-1:0]   pwm_duty_cycle,
  output logic [NUM_PINS-1:0] out
);

  pwm_cfg_t            cfg;
  logic [CNT_W-1:0]    pwm_cnt;
  logic                tick;
  logic                period_end;
  logic [DUTY_W-1:0]   duty_q;
  logic                pwm_lvl;
  logic [NUM_PINS-1:0] out_d;
  logic                unused_tick;

  assign cfg = '{
    en_out: {en_reg_out_15_8, en_reg_out_7_0},
    en_pwm: {en_reg_pwm_15_8, en_reg_pwm_7_0},
    duty:   pwm_duty_cycle
  };

  pwm_timebase #(
    .CLK_DIV(CLK_DIV)
  ) u_timebase (
    .clk        (clk),
    .rst        (rst),
    .pwm_cnt    (pwm_cnt),
    .tick       (tick),
    .period_end (period_end)
  );

  // The top only needs the period boundary; the raw step strobe is not used here
  assign unused_tick = tick;

  // Duty shadow only reloads at the period boundary so pulses are never truncated
  always_ff @(posedge clk) begin
    if (rst) begin
      duty_q <= '0;
    end else if (period_end) begin
      duty_q <= cfg.duty;
    end
  end

  assign pwm_lvl = pwm_level(pwm_cnt, duty_q);

  // Per-pin output select; enables and mode bits act without shadowing
  always_comb begin
    out_d = '0;
    for (int i = 0; i < NUM_PINS; i++) begin
      case (pin_mode(cfg.en_out[i], cfg.en_pwm[i]))
        PIN_HIGH: out_d[i] = 1'b1;
        PIN_PWM:  out_d[i] = pwm_lvl;
        default:  out_d[i] = 1'b0;
      endcase
    end
  end

  // Output register feeding the pads directly
  always_ff @(posedge clk) begin
    if (rst) begin
      out <= '0;
    end else begin
      out <= out_d;
    end
  end

endmodule

// File: tb/tb_pwm_peripheral.sv
// Self-checking bench for pwm_peripheral: vector table with an expectation queue plus timed waveform sequences.
module tb_pwm_peripheral;

  typedef struct {
    logic        rst;
    logic [15:0] en_out;
    logic [15:0] en_pwm;
    logic [7:0]  duty;
    logic [15:0] exp_out;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] en_out;
  logic [15:0] en_pwm;
  logic [7:0]  duty;
  logic [15:0] o2;
  logic [15:0] o13;

  int checks  = 0;
  int errors  = 0;
  int mux_bad = 0;

  logic [15:0] exp_q[$];
  vec_t        vecs[12];

  always #5 clk = ~clk;

  pwm_peripheral #(.CLK_DIV(2)) dut (
    .clk             (clk),
    .rst             (rst),
    .en_reg_out_7_0  (en_out[7:0]),
    .en_reg_out_15_8 (en_out[15:8]),
    .en_reg_pwm_7_0  (en_pwm[7:0]),
    .en_reg_pwm_15_8 (en_pwm[15:8]),
    .pwm_duty_cycle  (duty),
    .out             (o2)
  );

  pwm_peripheral #(.CLK_DIV(13)) dut13 (
    .clk             (clk),
    .rst             (rst),
    .en_reg_out_7_0  (en_out[7:0]),
    .en_reg_out_15_8 (en_out[15:8]),
    .en_reg_pwm_7_0  (en_pwm[7:0]),
    .en_reg_pwm_15_8 (en_pwm[15:8]),
    .pwm_duty_cycle  (duty),
    .out             (o13)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Sample bit 15 at the falling edge; for the CLK_DIV=2 instance also verify the whole pin mux
  task automatic sample(input bit use13, output logic b);
    @(negedge clk);
    if (use13) begin
      b = o13[15];
    end else begin
      b = o2[15];
      if (o2 !== ((en_out & ~en_pwm) | (en_out & en_pwm & {16{b}}))) mux_bad++;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_rise(input bit use13, input int limit, output bit ok);
    logic prev;
    logic cur;
    ok = 1'b0;
    sample(use13, prev);
    for (int k = 0; k < limit; k++) begin
      sample(use13, cur);
      if (!prev && cur) begin
        ok = 1'b1;
        break;
      end
      prev = cur;
    end
  endtask

  // High time and period of one pulse, starting from the next rising edge
  task automatic measure(input bit use13, input int limit, output int hi, output int per);
    bit   ok;
    logic b;
    int   lo;
    hi  = -1;
    per = -1;
    wait_rise(use13, limit, ok);
    if (ok) begin
      hi = 1;
      lo = 0;
      for (int k = 0; k < limit; k++) begin
        sample(use13, b);
        if (b) hi++;
        else begin
          lo = 1;
          break;
        end
      end
      for (int k = 0; k < limit; k++) begin
        sample(use13, b);
        if (!b) lo++;
        else break;
      end
      per = hi + lo;
    end
  endtask

  task automatic count_high(input int n, output int hi);
    logic b;
    hi = 0;
    for (int k = 0; k < n; k++) begin
      sample(1'b0, b);
      if (b) hi++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          hi, per, hi_a, per_a, hi_b, per_b, h, m, zeros, lo;
    int          hi1, lo1, hi2, lo2;
    bit          ok;
    logic        b;
    logic [15:0] e;

    rst    = 1'b1;
    en_out = 16'hFFFF;
    en_pwm = 16'h0000;
    duty   = 8'h80;

    vecs[0]  = '{1'b1, 16'hFFFF, 16'h0000, 8'h80, 16'h0000};
    vecs[1]  = '{1'b1, 16'hFFFF, 16'h0000, 8'h80, 16'h0000};
    vecs[2]  = '{1'b1, 16'hFFFF, 16'h0000, 8'h80, 16'h0000};
    vecs[3]  = '{1'b0, 16'hFFFF, 16'h0000, 8'h80, 16'hFFFF};
    vecs[4]  = '{1'b0, 16'h00F0, 16'h0000, 8'h80, 16'h00F0};
    vecs[5]  = '{1'b0, 16'h00F0, 16'h00FF, 8'h80, 16'h0000};
    vecs[6]  = '{1'b0, 16'hFF0F, 16'h0F00, 8'h80, 16'hF00F};
    vecs[7]  = '{1'b0, 16'h0000, 16'hFFFF, 8'hFF, 16'h0000};
    vecs[8]  = '{1'b0, 16'hFFFF, 16'hFFFF, 8'hFF, 16'h0000};
    vecs[9]  = '{1'b0, 16'h1234, 16'h0000, 8'h00, 16'h1234};
    vecs[10] = '{1'b0, 16'hFFFF, 16'h8000, 8'h40, 16'h7FFF};
    vecs[11] = '{1'b0, 16'hA5A5, 16'h5A5A, 8'h80, 16'hA5A5};

    // Vector table: each record drives one cycle, its expectation is due one clock later
    @(negedge clk);
    foreach (vecs[i]) begin
      rst    = vecs[i].rst;
      en_out = vecs[i].en_out;
      en_pwm = vecs[i].en_pwm;
      duty   = vecs[i].duty;
      exp_q.push_back(vecs[i].exp_out);
      @(negedge clk);
      e = exp_q.pop_front();
      check($sformatf("vec%0d_div2", i), 32'(o2), 32'(e));
      check($sformatf("vec%0d_div13", i), 32'(o13), 32'(e));
    end

    // 50% duty on both prescaler settings, measured from the first loaded period
    en_out = 16'hFFFF;
    en_pwm = 16'hFFFF;
    duty   = 8'h80;
    fork
      measure(1'b0, 2000, hi_a, per_a);
      measure(1'b1, 8000, hi_b, per_b);
    join
    check("duty80_high_div2", 32'(hi_a), 32'd256);
    check("duty80_period_div2", 32'(per_a), 32'd512);
    check("duty80_high_div13", 32'(hi_b), 32'd1664);
    check("duty80_period_div13", 32'(per_b), 32'd3328);

    // Duty extremes
    duty = 8'h00;
    idle(514);
    count_high(1536, h);
    check("duty00_high_cycles", 32'(h), 32'd0);

    duty = 8'hFF;
    idle(514);
    count_high(1536, h);
    check("dutyFF_high_cycles", 32'(h), 32'd1536);

    duty = 8'h01;
    measure(1'b0, 1200, hi, per);
    check("duty01_high", 32'(hi), 32'd2);
    check("duty01_period", 32'(per), 32'd512);

    // Mid-period duty change: write 0xC0 while pwm_cnt is 0x20 in a 0x40 period
    duty = 8'h40;
    idle(514);
    wait_rise(1'b0, 600, ok);
    check("midchg_rise_found", 32'(ok), 32'd1);
    hi1 = 1;
    m   = 0;
    for (int k = 0; k < 600; k++) begin
      sample(1'b0, b);
      m++;
      if (m == 63) duty = 8'hC0;
      if (b) hi1++;
      else break;
    end
    lo1 = 1;
    for (int k = 0; k < 600; k++) begin
      sample(1'b0, b);
      if (!b) lo1++;
      else break;
    end
    hi2 = 1;
    for (int k = 0; k < 600; k++) begin
      sample(1'b0, b);
      if (b) hi2++;
      else break;
    end
    lo2 = 1;
    for (int k = 0; k < 600; k++) begin
      sample(1'b0, b);
      if (!b) lo2++;
      else break;
    end
    check("midchg_cur_high", 32'(hi1), 32'd128);
    check("midchg_cur_period", 32'(hi1 + lo1), 32'd512);
    check("midchg_next_high", 32'(hi2), 32'd384);
    check("midchg_next_period", 32'(hi2 + lo2), 32'd512);

    // Reset at pwm_cnt 0x90 with duty 0x80; low byte static high so the output clear is visible
    en_pwm = 16'hFF00;
    duty   = 8'h80;
    idle(514);
    wait_rise(1'b0, 600, ok);
    check("rstmid_rise_found", 32'(ok), 32'd1);
    idle(287);
    rst = 1'b1;
    @(negedge clk);
    check("rstmid_out_div2", 32'(o2), 32'd0);
    check("rstmid_out_div13", 32'(o13), 32'd0);
    rst = 1'b0;
    zeros = 0;
    for (int k = 0; k < 700; k++) begin
      sample(1'b0, b);
      if (!b) zeros++;
      else break;
    end
    check("rstmid_first_period_low", 32'(zeros), 32'd512);
    hi = 1;
    for (int k = 0; k < 700; k++) begin
      sample(1'b0, b);
      if (b) hi++;
      else break;
    end
    check("rstmid_second_period_high", 32'(hi), 32'd256);
    lo = 1;
    for (int k = 0; k < 700; k++) begin
      sample(1'b0, b);
      if (!b) lo++;
      else break;
    end
    check("rstmid_second_period", 32'(hi + lo), 32'd512);

    check("pin_mux_consistency", 32'(mux_bad), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
